// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_FAIL     = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_DEVERR = 8'hFC;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_RETRY  = 2'd1;
    localparam logic [1:0] ERR_DEVERR = 2'd2;
    localparam logic [1:0] ERR_RSP_TO = 2'd3;

    localparam int CMD_W = 10;

    // Queue entry layout: response count in the top bits, command byte below.
    function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0] nrsp, input logic [7:0] cmd);
        return {nrsp, cmd};
    endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Command queue: DEPTH x WIDTH synchronous FIFO with registered full/empty flags.
module ps2_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests and compute the next occupancy.
    always_comb begin
        push_ok_s  = push && !full_r;
        pop_ok_s   = pop && !empty_r;
        count_nx_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + (AW+1)'(1);
            2'b01:   count_nx_s = count_r - (AW+1)'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CNT_FULL);
            empty_r <= (count_nx_s == '0);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/ps2_cmd_sched.sv
// PS/2 host command sequencer: sends queued bytes one at a time, handles
// ACK/resend/timeout, collects responses and forwards unsolicited scan codes.
module ps2_cmd_sched
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_byte,
    input  logic [1:0] cmd_nrsp,
    input  logic       cmd_push,
    output logic       cmd_full,
    output logic [7:0] tx_byte,
    output logic       tx_req,
    input  logic       tx_ack,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] scan_byte,
    output logic       scan_valid,
    output logic [7:0] rsp_byte,
    output logic       rsp_valid,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    ps2_state_e       state_r, state_nx_s;
    logic [7:0]       cur_byte_r;
    logic [1:0]       cur_nrsp_r;
    logic [1:0]       rcnt_r;
    logic [RW-1:0]    retry_r, retry_nx_s;
    logic [TW-1:0]    timer_r;
    logic             timeout_s;
    logic             fifo_pop_s, fifo_empty_s, fifo_full_s;
    logic [CMD_W-1:0] fifo_dout_s;
    logic             done_nx_s, scan_nx_s, rsp_nx_s;
    logic [1:0]       code_nx_s;
    logic             tx_req_r, done_r, err_r, scan_valid_r, rsp_valid_r, busy_r;
    logic [7:0]       tx_byte_r, scan_byte_r, rsp_byte_r;
    logic [1:0]       err_code_r;

    ps2_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_push),
        .pop   (fifo_pop_s),
        .din   (pack_cmd(cmd_nrsp, cmd_byte)),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and pulse decode; the RETRY decision is folded into its callers.
    always_comb begin
        state_nx_s = state_r;
        retry_nx_s = retry_r;
        fifo_pop_s = 1'b0;
        done_nx_s  = 1'b0;
        scan_nx_s  = 1'b0;
        rsp_nx_s   = 1'b0;
        code_nx_s  = ERR_NONE;
        timeout_s  = (timer_r == TMAX);
        case (state_r)
            ST_IDLE: begin
                scan_nx_s = rx_valid;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    retry_nx_s = '0;
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                scan_nx_s = rx_valid;
                if (tx_ack) state_nx_s = ST_WAIT_TX;
                else        state_nx_s = ST_SEND;
            end
            ST_WAIT_TX: begin
                scan_nx_s = rx_valid;
                if (tx_err) begin
                    if (retry_r < RMAX) begin
                        retry_nx_s = retry_r + RW'(1);
                        state_nx_s = ST_SEND;
                    end else begin
                        state_nx_s = ST_FAIL;
                        code_nx_s  = ERR_RETRY;
                    end
                end else if (tx_done) begin
                    state_nx_s = ST_WAIT_ACK;
                end else begin
                    state_nx_s = ST_WAIT_TX;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    case (rx_byte)
                        PS2_ACK: begin
                            if (cur_nrsp_r == 2'd0) begin
                                done_nx_s  = 1'b1;
                                state_nx_s = ST_IDLE;
                            end else begin
                                state_nx_s = ST_WAIT_RSP;
                            end
                        end
                        PS2_DEVERR: begin
                            state_nx_s = ST_FAIL;
                            code_nx_s  = ERR_DEVERR;
                        end
                        PS2_RESEND: begin
                            if (retry_r < RMAX) begin
                                retry_nx_s = retry_r + RW'(1);
                                state_nx_s = ST_SEND;
                            end else begin
                                state_nx_s = ST_FAIL;
                                code_nx_s  = ERR_RETRY;
                            end
                        end
                        default: scan_nx_s = 1'b1;
                    endcase
                end else if (timeout_s) begin
                    if (retry_r < RMAX) begin
                        retry_nx_s = retry_r + RW'(1);
                        state_nx_s = ST_SEND;
                    end else begin
                        state_nx_s = ST_FAIL;
                        code_nx_s  = ERR_RETRY;
                    end
                end else begin
                    state_nx_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_RSP: begin
                if (rx_valid) begin
                    rsp_nx_s = 1'b1;
                    if (rcnt_r == 2'd1) begin
                        done_nx_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_WAIT_RSP;
                    end
                end else if (timeout_s) begin
                    state_nx_s = ST_FAIL;
                    code_nx_s  = ERR_RSP_TO;
                end else begin
                    state_nx_s = ST_WAIT_RSP;
                end
            end
            ST_FAIL: begin
                scan_nx_s  = rx_valid;
                state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, command context, timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cur_byte_r   <= 8'h00;
            cur_nrsp_r   <= 2'd0;
            rcnt_r       <= 2'd0;
            retry_r      <= '0;
            timer_r      <= '0;
            tx_req_r     <= 1'b0;
            tx_byte_r    <= 8'h00;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
            scan_valid_r <= 1'b0;
            scan_byte_r  <= 8'h00;
            rsp_valid_r  <= 1'b0;
            rsp_byte_r   <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            retry_r <= retry_nx_s;
            if (fifo_pop_s) begin
                cur_byte_r <= fifo_dout_s[7:0];
                cur_nrsp_r <= fifo_dout_s[9:8];
                tx_byte_r  <= fifo_dout_s[7:0];
            end
            if (state_r == ST_WAIT_ACK && state_nx_s == ST_WAIT_RSP) rcnt_r <= cur_nrsp_r;
            else if (rsp_nx_s)                                       rcnt_r <= rcnt_r - 2'd1;
            // Any state change or accepted response byte restarts the wait window.
            if (state_nx_s != state_r || rsp_nx_s)
                timer_r <= '0;
            else if ((state_r == ST_WAIT_ACK || state_r == ST_WAIT_RSP) && !timeout_s)
                timer_r <= timer_r + TW'(1);
            tx_req_r     <= (state_nx_s == ST_SEND);
            done_r       <= done_nx_s;
            err_r        <= (state_nx_s == ST_FAIL);
            err_code_r   <= code_nx_s;
            scan_valid_r <= scan_nx_s;
            if (scan_nx_s) scan_byte_r <= rx_byte;
            rsp_valid_r  <= rsp_nx_s;
            if (rsp_nx_s) rsp_byte_r <= rx_byte;
            busy_r       <= (state_r != ST_IDLE) || !fifo_empty_s;
        end
    end

    assign cmd_full   = fifo_full_s;
    assign tx_req     = tx_req_r;
    assign tx_byte    = tx_byte_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign scan_valid = scan_valid_r;
    assign scan_byte  = scan_byte_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_byte   = rsp_byte_r;
    assign busy       = busy_r;

endmodule
